// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: round-robin sharing of one single-port memory read port.
// Each read holds strobe and address for RD_CYCLES clocks, followed by a
// one-cycle idle gap. Read data goes back to the winner with a one-cycle
// rvalid pulse. All outputs come straight from flops.

module mem_rd_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_ce,
  output logic                 mem_rd,
  output logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_CYCLES - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_rd_q, mem_rd_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;

  logic [PW-1:0]     win_s;
  logic              found_s;
  logic [PW:0]       cand_s;

  // Round-robin pick: first asserted request at or after the pointer, wrapping.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand_s >= (PW+1)'(NREQ)) begin
        cand_s = cand_s - (PW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[PW-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[PW-1:0];
      end else begin
        found_s = found_s;
        win_s   = win_s;
      end
    end
  end

  // Read sequencer: next state, arbitration bookkeeping and output values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        // mem_ce_q must already be high so the strobe never leads chip enable.
        if (en && mem_ce_q && found_s) begin
          state_d      = ST_READ;
          win_d        = win_s;
          ptr_d        = (win_s == IDX_LAST) ? '0 : win_s + PW'(1);
          cnt_d        = '0;
          mem_rd_d     = 1'b1;
          mem_addr_d   = req_addr[int'(win_s)*AW +: AW];
          gnt_d[win_s] = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // en and req are deliberately ignored until the read finishes.
        if (cnt_q == CNT_LAST) begin
          state_d         = ST_GAP;
          cnt_d           = '0;
          mem_rd_d        = 1'b0;
          rdata_d         = mem_rdata;
          rvalid_d[win_q] = 1'b1;
        end else begin
          state_d  = ST_READ;
          cnt_d    = cnt_q + CW'(1);
          mem_rd_d = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Chip enable tracks en while idle but stays up for any read under way.
    mem_ce_d = en | (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight read silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_ce_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      mem_ce_q   <= mem_ce_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_ce   = mem_ce_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

  mem_rd_arbiter_chk #(
    .NREQ (NREQ),
    .AW   (AW)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .gnt      (gnt_q),
    .rvalid   (rvalid_q),
    .mem_ce   (mem_ce_q),
    .mem_rd   (mem_rd_q),
    .mem_addr (mem_addr_q)
  );

endmodule

// Protocol invariants on the memory-side and requester-side outputs.
module mem_rd_arbiter_chk #(
  parameter int NREQ = 2,
  parameter int AW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] gnt,
  input  logic [NREQ-1:0] rvalid,
  input  logic            mem_ce,
  input  logic            mem_rd,
  input  logic [AW-1:0]   mem_addr
);

  a_rd_under_ce: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rd |-> mem_ce);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rvalid));

  a_gnt_starts_read: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt != '0) |-> mem_rd);

  a_rvalid_after_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    (rvalid != '0) |-> !mem_rd);

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_rd && $past(mem_rd)) |-> $stable(mem_addr));

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter (NREQ=2, AW=8, DW=8, RD_CYCLES=2).
// Memory model returns addr ^ 8'h99 while the strobe is high.

module tb_mem_rd_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  req;
  logic [15:0] req_addr;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [7:0]  rdata;
  logic        mem_ce;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;

  int n_chk;
  int n_err;

  mem_rd_arbiter #(
    .NREQ      (2),
    .AW        (8),
    .DW        (8),
    .RD_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_ce    (mem_ce),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem_rd ? (mem_addr ^ 8'h99) : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and compare the registered outputs.
  task automatic tick(input string tag, input logic [1:0] g, input logic rd,
                      input logic ce, input logic [1:0] rv, input logic [7:0] a);
    @(negedge clk);
    check_eq({tag, "_gnt"},    32'(gnt),      32'(g));
    check_eq({tag, "_mem_rd"}, 32'(mem_rd),   32'(rd));
    check_eq({tag, "_mem_ce"}, 32'(mem_ce),   32'(ce));
    check_eq({tag, "_rvalid"}, 32'(rvalid),   32'(rv));
    check_eq({tag, "_addr"},   32'(mem_addr), 32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] eg;
    logic [1:0] ev;
    logic       erd;
    logic [7:0] ea;
    int         ph;
    int         who;

    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = 2'b00;
    req_addr = 16'h0000;

    // Reset state
    @(negedge clk);
    check_eq("rst_gnt",    32'(gnt),      32'h0);
    check_eq("rst_rvalid", 32'(rvalid),   32'h0);
    check_eq("rst_mem_ce", 32'(mem_ce),   32'h0);
    check_eq("rst_mem_rd", 32'(mem_rd),   32'h0);
    check_eq("rst_addr",   32'(mem_addr), 32'h0);
    check_eq("rst_rdata",  32'(rdata),    32'h0);
    rst_n = 1'b1;

    // 1: single read from requester 0
    en = 1'b1;
    tick("t1_ce", 2'b00, 1'b0, 1'b1, 2'b00, 8'h00);
    req = 2'b01; req_addr[7:0] = 8'h3C;
    tick("t1_gnt", 2'b01, 1'b1, 1'b1, 2'b00, 8'h3C);
    req = 2'b00;
    tick("t1_rd2", 2'b00, 1'b1, 1'b1, 2'b00, 8'h3C);
    tick("t1_rv", 2'b00, 1'b0, 1'b1, 2'b01, 8'h3C);
    check_eq("t1_rdata", 32'(rdata), 32'hA5);
    tick("t1_gap", 2'b00, 1'b0, 1'b1, 2'b00, 8'h3C);
    check_eq("t1_rdata_hold", 32'(rdata), 32'hA5);

    // 2: contention, pointer restarted by reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick("t2_pre", 2'b00, 1'b0, 1'b1, 2'b00, 8'h00);
    req = 2'b11; req_addr = {8'h20, 8'h10};
    for (int i = 0; i < 16; i++) begin
      ph  = i % 4;
      who = (i / 4) % 2;
      eg  = (ph == 0) ? 2'(1 << who) : 2'b00;
      ev  = (ph == 2) ? 2'(1 << who) : 2'b00;
      erd = (ph < 2);
      ea  = (who == 1) ? 8'h20 : 8'h10;
      tick("t2_rr", eg, erd, 1'b1, ev, ea);
      if (ph == 2) begin
        check_eq("t2_rdata", 32'(rdata), (who == 1) ? 32'hB9 : 32'h89);
      end
    end
    req = 2'b00;

    // 3: enable gating
    en = 1'b0;
    tick("t3_off", 2'b00, 1'b0, 1'b0, 2'b00, 8'h20);
    req = 2'b01; req_addr[7:0] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick("t3_gated", 2'b00, 1'b0, 1'b0, 2'b00, 8'h20);
    end
    en = 1'b1;
    tick("t3_ce", 2'b00, 1'b0, 1'b1, 2'b00, 8'h20);
    tick("t3_gnt", 2'b01, 1'b1, 1'b1, 2'b00, 8'h55);
    req = 2'b00;
    tick("t3_rd2", 2'b00, 1'b1, 1'b1, 2'b00, 8'h55);
    tick("t3_rv", 2'b00, 1'b0, 1'b1, 2'b01, 8'h55);
    check_eq("t3_rdata", 32'(rdata), 32'hCC);
    tick("t3_gap", 2'b00, 1'b0, 1'b1, 2'b00, 8'h55);

    // 4: en dropped during first strobe cycle
    req = 2'b10; req_addr[15:8] = 8'h77;
    tick("t4_gnt", 2'b10, 1'b1, 1'b1, 2'b00, 8'h77);
    en = 1'b0; req = 2'b00;
    tick("t4_rd2", 2'b00, 1'b1, 1'b1, 2'b00, 8'h77);
    tick("t4_rv", 2'b00, 1'b0, 1'b1, 2'b10, 8'h77);
    check_eq("t4_rdata", 32'(rdata), 32'hEE);
    tick("t4_ce_fall", 2'b00, 1'b0, 1'b0, 2'b00, 8'h77);

    // 5: asynchronous reset in the middle of a read
    en = 1'b1;
    tick("t5_ce", 2'b00, 1'b0, 1'b1, 2'b00, 8'h77);
    req = 2'b01; req_addr = {8'h4D, 8'h3C};
    tick("t5_gnt", 2'b01, 1'b1, 1'b1, 2'b00, 8'h3C);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_rd",  32'(mem_rd), 32'h0);
    check_eq("t5_async_ce",  32'(mem_ce), 32'h0);
    check_eq("t5_async_gnt", 32'(gnt),    32'h0);
    req = 2'b11;
    @(negedge clk);
    check_eq("t5_no_rvalid", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
    tick("t5_rel", 2'b00, 1'b0, 1'b1, 2'b00, 8'h00);
    tick("t5_first", 2'b01, 1'b1, 1'b1, 2'b00, 8'h3C);
    req = 2'b00;
    tick("t5_rd2", 2'b00, 1'b1, 1'b1, 2'b00, 8'h3C);
    tick("t5_rv", 2'b00, 1'b0, 1'b1, 2'b01, 8'h3C);
    check_eq("t5_rdata", 32'(rdata), 32'hA5);
    tick("t5_gap", 2'b00, 1'b0, 1'b1, 2'b00, 8'h3C);

    // 6: requester 1 pulses req only while requester 0 is reading
    req = 2'b01; req_addr[7:0] = 8'h21;
    tick("t6_gnt", 2'b01, 1'b1, 1'b1, 2'b00, 8'h21);
    req = 2'b10;
    tick("t6_pulse", 2'b00, 1'b1, 1'b1, 2'b00, 8'h21);
    req = 2'b00;
    tick("t6_rv", 2'b00, 1'b0, 1'b1, 2'b01, 8'h21);
    check_eq("t6_rdata", 32'(rdata), 32'hB8);
    for (int i = 0; i < 4; i++) begin
      tick("t6_quiet", 2'b00, 1'b0, 1'b1, 2'b00, 8'h21);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares one single-port memory read interface (chip enable, read strobe, address, read data) between NREQ requesters using round-robin arbitration.
- Sequences each read so that the read strobe and address are held stable for exactly RD_CYCLES clocks, with a mandatory idle gap between reads.
- Returns captured read data to the winning requester with a one-cycle valid pulse.
- Sits between client engines and the memory macro; its mem_* outputs are what the memory-protocol assertions check.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 8, address width
DW, 8, data width
RD_CYCLES, 2, clocks the read strobe and address are held per read (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  controller enable; drives memory chip enable
req  input  NREQ  per-requester read request, level, held until gnt
req_addr  input  NREQ*AW  per-requester address, slice i = [i*AW +: AW]
gnt  output  NREQ  one-hot, one-cycle pulse: request accepted, address latched
rvalid  output  NREQ  one-hot, one-cycle pulse: rdata valid for that requester
rdata  output  DW  read data, held until next rvalid
mem_ce  output  1  memory chip enable
mem_rd  output  1  memory read strobe
mem_addr  output  AW  memory address
mem_rdata  input  DW  memory read data, valid during final strobe cycle

Behaviour:
- All outputs are registered.
- Reset (rst_n low, asynchronous):
  - gnt, rvalid, mem_ce and mem_rd = 0; mem_addr and rdata = 0.
  - Round-robin pointer = 0; state = IDLE.
  - An in-flight read is dropped and no rvalid is issued.
- States: IDLE, READ, GAP.
- mem_ce register: next = en OR (next state != IDLE). mem_ce therefore follows en with one cycle delay in IDLE and is forced high until a started read completes.
- IDLE:
  - At an edge where en=1, mem_ce=1 and req != 0, choose winner w: the first set req bit at or after the pointer, wrapping.
  - Next-cycle outputs: mem_addr = req_addr[w], mem_rd = 1, gnt[w] = 1 for one cycle.
  - Pointer becomes (w+1) mod NREQ; beat counter = 0; go to READ.
  - If req is asserted but mem_ce=0 (first cycle after en rises), no grant.
- READ:
  - mem_rd = 1 and mem_addr held constant for exactly RD_CYCLES cycles; the counter increments each cycle.
  - On the edge ending the last strobe cycle: rdata <= mem_rdata, rvalid[w] <= 1, mem_rd <= 0; go to GAP.
  - req and en changes during READ have no effect on the read in progress.
- GAP:
  - One cycle with mem_rd = 0, then return to IDLE.
  - mem_addr keeps its last value; it changes only when mem_rd rises.
- Throughput: one read per RD_CYCLES+2 clocks.
- Latency from req sampled to rvalid: RD_CYCLES+1 edges.
- A requester dropping req before gnt is never granted and loses no state.
- A requester that keeps req high after gnt is re-requesting; it is granted again when its round-robin turn comes.
- Simultaneous requests: strictly round-robin; no requester waits more than NREQ-1 other grants.
- en dropping mid-read: the read completes, then mem_ce falls on the edge leaving GAP into IDLE.
- mem_rd is never high while mem_ce is low.

Test Plan:
1. Single read, NREQ=2, RD_CYCLES=2. en=1, req=01, req_addr[0]=8'h3C, mem_rdata=8'hA5 during strobe -> gnt=01 for one cycle; mem_rd high exactly 2 cycles with mem_addr=3C stable; rvalid=01 one cycle; rdata=A5.
2. Contention. req=11 held continuously, addr0=10, addr1=20 -> grants alternate 01,10,01,10. mem_addr sequence is 10,20,10,20 with a one-cycle mem_rd low gap between reads; reads start every 4 clocks.
3. Enable gating. req=01 with en=0 for 5 cycles -> no gnt, mem_ce=0, mem_rd=0. en rises -> mem_ce=1 next cycle, gnt the cycle after.
4. en dropped mid-read. en falls during the first strobe cycle -> strobe still lasts 2 cycles; rvalid is issued; mem_ce falls on leaving GAP.
5. Asynchronous reset mid-read. rst_n low between edges during READ -> mem_rd, mem_ce and gnt drop immediately; no rvalid; pointer=0. After release with req=11, the first grant goes to requester 0.
6. Early withdrawal. req[1] pulses for one cycle while requester 0 is in READ -> no gnt[1] is ever issued; requester 0 completes normally.
